// File: rtl/hram_if.sv
// Native memory port (valid/ready, 32-bit word) between the bus master and the HyperRAM controller.
// The master drives the request fields; the controller returns a one-cycle ready and the read data.
interface hram_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        valid;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output addr,
    output wdata,
    output wstrb,
    output valid,
    input  ready,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  wstrb,
    input  valid,
    output ready,
    output rdata
  );
endinterface

// File: rtl/hram.sv
// HyperRAM controller: maps one 32-bit native word access onto one x16 HyperBus burst of two words.
// ck runs at clk/2; every bus word is a drive cycle (A) followed by a ck-toggle cycle (B).
module hram #(
  parameter int LATENCY  = 6,
  parameter int RECOVERY = 4
) (
  input  logic        clk,
  input  logic        resetn,
  hram_if.slave       bus,
  inout  wire  [15:0] adq,
  inout  wire  [1:0]  dqs,
  output logic        ck,
  output logic        ce
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CS   = 3'd1;
  localparam logic [2:0] S_CA   = 3'd2;
  localparam logic [2:0] S_LAT  = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_TAIL = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;
  localparam logic [2:0] S_REC  = 3'd7;

  localparam logic [7:0] CA_LAST   = 8'd5;
  localparam logic [7:0] LAT_LAST  = 8'(8 * LATENCY - 1);
  localparam logic [7:0] DATA_LAST = 8'd3;
  localparam logic [7:0] TAIL_LAST = 8'd1;
  localparam logic [7:0] REC_LAST  = 8'(RECOVERY - 1);

  logic [2:0]  r_state;
  logic [7:0]  r_cnt;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_ce;
  logic        r_ck;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic [31:0] r_rd_buf;
  logic [15:0] r_adq_out;
  logic        r_adq_oe;
  logic [1:0]  r_dqs_out;
  logic        r_dqs_oe;

  logic [2:0]  w_state_next;
  logic        w_phase_b;
  logic        w_ck_active;
  logic        w_is_read;
  logic        w_accept;
  logic [30:0] w_ha;
  logic [47:0] w_ca;
  logic [1:0]  w_mask0;
  logic [1:0]  w_mask1;
  wire         w_unused_addr = ^bus.addr[1:0];

  assign w_phase_b   = r_cnt[0];
  assign w_ck_active = (r_state == S_CA) || (r_state == S_LAT) ||
                       (r_state == S_DATA) || (r_state == S_TAIL);
  assign w_is_read   = (r_wstrb == 4'b0000);
  assign w_accept    = (r_state == S_IDLE) && bus.valid;

  // Command word: R/W, memory space, linear burst, row/upper column, lower column.
  assign w_ha = {r_addr, 1'b0};
  assign w_ca = {w_is_read, 1'b0, 1'b1, 1'b0, w_ha[30:3], 13'd0, w_ha[2:0]};

  // RWDS is a byte mask during writes: high means the byte is not written.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign w_mask0[gi] = ~r_wstrb[gi];
      assign w_mask1[gi] = ~r_wstrb[gi + 2];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (bus.valid) w_state_next = S_CS;
      S_CS:   w_state_next = S_CA;
      S_CA:   if (r_cnt == CA_LAST) w_state_next = S_LAT;
      S_LAT:  if (r_cnt == LAT_LAST) w_state_next = S_DATA;
      S_DATA: if (r_cnt == DATA_LAST) w_state_next = S_TAIL;
      S_TAIL: if (r_cnt == TAIL_LAST) w_state_next = S_DONE;
      S_DONE: w_state_next = S_REC;
      S_REC:  if (r_cnt == REC_LAST) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      if ((w_state_next != r_state) || (r_state == S_IDLE))
        r_cnt <= 8'd0;
      else
        r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr  <= 30'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
    end else if (w_accept) begin
      r_addr  <= bus.addr[31:2];
      r_wdata <= bus.wdata;
      r_wstrb <= bus.wstrb;
    end
  end

  // ck toggles on every B cycle of an active state; the edge count per burst is even, so it ends low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ce    <= 1'b1;
      r_ck    <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_ce    <= !((w_state_next == S_CS) || (w_state_next == S_CA) ||
                   (w_state_next == S_LAT) || (w_state_next == S_DATA) ||
                   (w_state_next == S_TAIL));
      r_ready <= (w_state_next == S_DONE);
      if (w_ck_active && !w_phase_b)
        r_ck <= ~r_ck;
    end
  end

  // New bus words are registered at the edge that opens their A cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_adq_out <= 16'd0;
      r_adq_oe  <= 1'b0;
      r_dqs_out <= 2'b00;
      r_dqs_oe  <= 1'b0;
    end else begin
      if (r_state == S_CS) begin
        r_adq_out <= w_ca[47:32];
        r_adq_oe  <= 1'b1;
      end else if ((r_state == S_CA) && w_phase_b) begin
        if (r_cnt == 8'd1)
          r_adq_out <= w_ca[31:16];
        else if (r_cnt == 8'd3)
          r_adq_out <= w_ca[15:0];
        else
          r_adq_oe <= 1'b0;
      end else if ((r_state == S_LAT) && (w_state_next == S_DATA)) begin
        r_adq_out <= r_wdata[15:0];
        r_dqs_out <= w_mask0;
        r_adq_oe  <= !w_is_read;
        r_dqs_oe  <= !w_is_read;
      end else if ((r_state == S_DATA) && w_phase_b) begin
        if (r_cnt == 8'd1) begin
          r_adq_out <= r_wdata[31:16];
          r_dqs_out <= w_mask1;
        end else begin
          r_adq_oe <= 1'b0;
          r_dqs_oe <= 1'b0;
        end
      end
    end
  end

  // Read words are sampled at the end of each B cycle, mid-way between ck edges.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_buf <= 32'd0;
      r_rdata  <= 32'd0;
    end else begin
      if ((r_state == S_DATA) && w_phase_b) begin
        if (r_cnt == 8'd1)
          r_rd_buf[15:0] <= adq;
        else
          r_rd_buf[31:16] <= adq;
      end
      if ((r_state == S_TAIL) && (w_state_next == S_DONE) && w_is_read)
        r_rdata <= r_rd_buf;
    end
  end

  assign adq       = r_adq_oe ? r_adq_out : 16'hzzzz;
  assign dqs       = r_dqs_oe ? r_dqs_out : 2'bzz;
  assign ck        = r_ck;
  assign ce        = r_ce;
  assign bus.ready = r_ready;
  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_hram.sv
// Bench for hram: directed vector table, randomized requests against a rule-level model,
// plus hand-written reset-in-flight and back-to-back sequences.
module tb_hram;
  localparam int L        = 6;
  localparam int REC      = 4;
  localparam int READY_AT = 13 + 8 * L;
  localparam int EDGES    = 3 + 4 * L + 3;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [15:0] dev0;
    logic [15:0] dev1;
    logic [15:0] ca0;
    logic [15:0] ca1;
    logic [15:0] ca2;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  q0;
    logic [1:0]  q1;
    logic [31:0] rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  wire  [15:0] adq;
  wire  [1:0]  dqs;
  logic        ck;
  logic        ce;
  logic        dev_oe = 1'b0;
  logic [15:0] dev_adq = 16'h0000;

  hram_if bus();

  assign adq = dev_oe ? dev_adq : 16'hzzzz;

  hram #(.LATENCY(L), .RECOVERY(REC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .adq    (adq),
    .dqs    (dqs),
    .ck     (ck),
    .ce     (ce)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] m_ca [3];
  logic [15:0] m_d [2];
  logic [1:0]  m_q [2];
  int          m_ready_at;
  int          m_ready_w;
  int          m_edges;
  logic        m_ce0;
  logic        m_ck0;
  logic        m_ck_end;
  logic        m_ce_end;
  logic        m_drive_lat;
  logic [31:0] m_rdata;
  logic [31:0] last_rdata = 32'h0;
  vec_t        vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Rule-level model: halfword address, command bit fields and byte masks from plain arithmetic.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                                 input logic [15:0] d0, input logic [15:0] d1, input logic [31:0] prev);
    vec_t v;
    longint unsigned ha;
    longint unsigned ca;
    ha = longint'(a / 4) * 2;
    ca = (64'd1 << 45) + ((ha / 8) << 16) + (ha % 8);
    if (ws == 4'd0) ca = ca + (64'd1 << 47);
    v.addr = a; v.wdata = wd; v.wstrb = ws; v.dev0 = d0; v.dev1 = d1;
    v.ca0 = 16'((ca / 65536 / 65536) % 65536);
    v.ca1 = 16'((ca / 65536) % 65536);
    v.ca2 = 16'(ca % 65536);
    v.d0 = wd[15:0];
    v.d1 = wd[31:16];
    for (int b = 0; b < 2; b++) begin
      v.q0[b] = (ws[b] == 1'b0);
      v.q1[b] = (ws[b + 2] == 1'b0);
    end
    v.rdata = (ws == 4'd0) ? {d1, d0} : prev;
    return v;
  endfunction

  // Issues one request and monitors the pins until ready drops. hold<0 keeps valid high.
  task automatic do_txn(input vec_t v, input int hold);
    int   e;
    logic pck;
    bus.addr  = v.addr;
    bus.wdata = v.wdata;
    bus.wstrb = v.wstrb;
    bus.valid = 1'b1;
    m_ready_at = -1; m_ready_w = 0; m_edges = 0; m_drive_lat = 1'b0;
    m_ck_end = 1'bx; m_ce_end = 1'bx; m_rdata = 32'hx;
    for (int i = 0; i < 3; i++) m_ca[i] = 16'hx;
    for (int i = 0; i < 2; i++) begin m_d[i] = 16'hx; m_q[i] = 2'bxx; end
    @(posedge clk); #1;
    m_ce0 = ce;
    m_ck0 = ck;
    pck = ck;
    e = 0;
    for (int n = 0; n < 4 * READY_AT; n++) begin
      if (hold >= 0 && n >= hold - 1) bus.valid = 1'b0;
      if (ck !== pck) begin
        e++;
        if (ce == 1'b0) m_edges++;
        if (e <= 3) m_ca[e - 1] = adq;
        else if (e <= 3 + 4 * L) m_drive_lat = m_drive_lat | dut.r_adq_oe | dut.r_dqs_oe;
        else if (e == 4 + 4 * L) begin m_d[0] = adq; m_q[0] = dqs; end
        else if (e == 5 + 4 * L) begin m_d[1] = adq; m_q[1] = dqs; end
        if (v.wstrb == 4'd0) begin
          if (e == 4 + 4 * L) begin dev_adq = v.dev0; dev_oe = 1'b1; end
          else if (e == 5 + 4 * L) dev_adq = v.dev1;
          else if (e == 6 + 4 * L) dev_oe = 1'b0;
        end
        pck = ck;
      end
      if (bus.ready) begin
        if (m_ready_at < 0) begin
          m_ready_at = n; m_ck_end = ck; m_ce_end = ce; m_rdata = bus.rdata;
        end
        m_ready_w++;
      end else if (m_ready_at >= 0) begin
        break;
      end
      @(posedge clk); #1;
    end
    dev_oe = 1'b0;
    $display("[TB] txn addr=%08h wstrb=%h ca=%04h_%04h_%04h rdata=%08h ready@%0d",
             v.addr, v.wstrb, m_ca[0], m_ca[1], m_ca[2], m_rdata, m_ready_at);
  endtask

  task automatic check_txn(input string tag, input vec_t v);
    check({tag, ".ca0"}, m_ca[0], v.ca0);
    check({tag, ".ca1"}, m_ca[1], v.ca1);
    check({tag, ".ca2"}, m_ca[2], v.ca2);
    if (v.wstrb != 4'd0) begin
      check({tag, ".d0"}, m_d[0], v.d0);
      check({tag, ".d1"}, m_d[1], v.d1);
      check({tag, ".dqs0"}, m_q[0], v.q0);
      check({tag, ".dqs1"}, m_q[1], v.q1);
    end
    check({tag, ".rdata"}, m_rdata, v.rdata);
    check({tag, ".ready_at"}, m_ready_at, READY_AT);
    check({tag, ".ready_width"}, m_ready_w, 1);
    check({tag, ".ck_edges"}, m_edges, EDGES);
    check({tag, ".ce_low_at_start"}, m_ce0, 1'b0);
    check({tag, ".ck_low_at_start"}, m_ck0, 1'b0);
    check({tag, ".ck_low_at_end"}, m_ck_end, 1'b0);
    check({tag, ".ce_high_at_end"}, m_ce_end, 1'b1);
    check({tag, ".lat_hiz"}, m_drive_lat, 1'b0);
    last_rdata = v.rdata;
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, ".ce"}, ce, 1'b1);
    check({tag, ".ck"}, ck, 1'b0);
    check({tag, ".ready"}, bus.ready, 1'b0);
    check({tag, ".rdata"}, bus.rdata, 32'h0);
    check({tag, ".hiz"}, {dut.r_adq_oe, dut.r_dqs_oe}, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   gap;
    int   rdy;

    vecs[0] = '{32'h0000_0000, 32'h1234_5678, 4'b1010, 16'h0000, 16'h0000,
                16'h2000, 16'h0000, 16'h0000, 16'h5678, 16'h1234, 2'b01, 2'b01, 32'h0000_0000};
    vecs[1] = '{32'h0000_0002, 32'h0000_0000, 4'b0000, 16'hBEEF, 16'hCAFE,
                16'hA000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 32'hCAFE_BEEF};
    vecs[2] = '{32'h0000_0010, 32'hA5A5_5A5A, 4'b1111, 16'h0000, 16'h0000,
                16'h2000, 16'h0001, 16'h0000, 16'h5A5A, 16'hA5A5, 2'b00, 2'b00, 32'hCAFE_BEEF};
    vecs[3] = '{32'hFFFF_FFFC, 32'h0000_0000, 4'b0000, 16'h1357, 16'h2468,
                16'hAFFF, 16'hFFFF, 16'h0006, 16'h0000, 16'h0000, 2'b00, 2'b00, 32'h2468_1357};
    vecs[4] = '{32'h0000_0006, 32'hDEAD_BEEF, 4'b0001, 16'h0000, 16'h0000,
                16'h2000, 16'h0000, 16'h0002, 16'hBEEF, 16'hDEAD, 2'b10, 2'b11, 32'h2468_1357};

    bus.addr = 32'h0; bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_pins("por");
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      do_txn(vecs[i], 5);
      check_txn($sformatf("vec%0d", i), vecs[i]);
      repeat (REC + 2) @(posedge clk);
      #1;
    end

    for (int i = 0; i < 24; i++) begin
      logic [3:0] ws;
      ws = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      v = model($urandom, $urandom, ws, 16'($urandom), 16'($urandom), last_rdata);
      do_txn(v, int'($urandom_range(1, 8)));
      check_txn($sformatf("rnd%0d", i), v);
      repeat (REC + 2) @(posedge clk);
      #1;
    end

    // Reset while the burst is waiting out the latency.
    bus.addr = 32'h0000_0040; bus.wdata = 32'h0BAD_F00D; bus.wstrb = 4'hF; bus.valid = 1'b1;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    check("rst.in_flight_ce", ce, 1'b0);
    resetn = 1'b0;
    #1;
    check_reset_pins("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    last_rdata = 32'h0;
    @(posedge clk); #1;
    v = model(32'h0000_0124, 32'h0, 4'h0, 16'h7E57, 16'h0A11, last_rdata);
    do_txn(v, 2);
    check_txn("post_rst", v);
    repeat (REC + 2) @(posedge clk);
    #1;

    // Back-to-back: valid stays high through ready; the next acceptance must wait out recovery.
    v = model(32'h0000_0200, 32'hFEED_C0DE, 4'hF, 16'h0, 16'h0, last_rdata);
    do_txn(v, -1);
    check_txn("b2b_first", v);
    gap = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ce == 1'b0) begin gap = k; break; end
    end
    bus.valid = 1'b0;
    check("b2b.gap", gap, REC + 1);
    rdy = -1;
    for (int n = 0; n < 4 * READY_AT; n++) begin
      if (bus.ready) begin rdy = n; break; end
      @(posedge clk); #1;
    end
    check("b2b.second_ready_at", rdy, READY_AT);
    $display("[TB] txn b2b second ready@%0d", rdy);
    @(posedge clk); #1;
    check("b2b.second_ready_width", bus.ready, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
